// File: rtl/lcd_frame_scanner.sv
// LCD frame scanner: walks a full H_PIXELS x V_PIXELS frame in raster order,
// presents each address to a pixel source, waits SRC_LATENCY cycles for the
// pixel, then offers it to the LCD bus writer with a valid/ready handshake.
module lcd_frame_scanner #(
    parameter int H_PIXELS    = 240,
    parameter int V_PIXELS    = 320,
    parameter int SRC_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic [7:0]  xAddLCD,
    output logic [8:0]  yAddLCD,
    input  logic [15:0] pixelData,
    output logic [15:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_first,
    output logic        busy,
    output logic        done
);

    localparam logic [7:0] X_LAST    = 8'(H_PIXELS - 1);
    localparam logic [8:0] Y_LAST    = 9'(V_PIXELS - 1);
    localparam logic [2:0] WAIT_LAST = 3'(SRC_LATENCY - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_SEND,
        ST_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  x_q, x_d;
    logic [8:0]  y_q, y_d;
    logic [2:0]  wait_q, wait_d;
    logic [7:0]  xadd_q, xadd_d;
    logic [8:0]  yadd_q, yadd_d;
    logic [15:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        first_q, first_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [7:0]  x_next;
    logic [8:0]  y_next;
    logic        last_pixel;

    // Raster successor of the current pixel, x fastest.
    always_comb begin
        x_next     = x_q;
        y_next     = y_q;
        last_pixel = (x_q == X_LAST) && (y_q == Y_LAST);
        if (x_q == X_LAST) begin
            x_next = '0;
            y_next = last_pixel ? '0 : y_q + 9'd1;
        end else begin
            x_next = x_q + 8'd1;
        end
    end

    // Next-state and registered-output logic of the scan FSM.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        wait_d  = wait_q;
        xadd_d  = xadd_q;
        yadd_d  = yadd_q;
        data_d  = data_q;
        valid_d = valid_q;
        first_d = first_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    x_d     = '0;
                    y_d     = '0;
                    wait_d  = '0;
                    xadd_d  = '0;
                    yadd_d  = '0;
                    busy_d  = 1'b1;
                end
            end

            ST_FETCH: begin
                wait_d = wait_q + 3'd1;
                if (wait_q == WAIT_LAST) begin
                    state_d = ST_LATCH;
                end
            end

            ST_LATCH: begin
                data_d  = pixelData;
                first_d = (x_q == '0) && (y_q == '0);
                valid_d = 1'b1;
                state_d = ST_SEND;
            end

            ST_SEND: begin
                if (pix_ready) begin
                    valid_d = 1'b0;
                    first_d = 1'b0;
                    wait_d  = '0;
                    x_d     = x_next;
                    y_d     = y_next;
                    // The address registers stay put on the last pixel so
                    // they only ever move when a new fetch begins.
                    if (last_pixel) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_FETCH;
                        xadd_d  = x_next;
                        yadd_d  = y_next;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers, asynchronously cleared.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            wait_q  <= '0;
            xadd_q  <= '0;
            yadd_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            wait_q  <= wait_d;
            xadd_q  <= xadd_d;
            yadd_q  <= yadd_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            first_q <= first_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign xAddLCD   = xadd_q;
    assign yAddLCD   = yadd_q;
    assign pix_data  = data_q;
    assign pix_valid = valid_q;
    assign pix_first = first_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_lcd_frame_scanner.sv
// Bench for lcd_frame_scanner: three instances (default size, small frame with
// 3-cycle source latency, 2x2 frame) driven by directed vectors and sequences.
module tb_lcd_frame_scanner;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Free-running clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [15:0] pix_of(input int x, input int y);
        logic [7:0] xb;
        logic [7:0] yb;
        xb = 8'(x);
        yb = 8'(y);
        return {yb ^ 8'hA5, xb ^ 8'h3C};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- instance 0: default parameters ----------------
    logic        s0, r0, v0, f0, b0, dn0;
    logic [7:0]  xa0;
    logic [8:0]  ya0;
    logic [15:0] pd0, d0;

    lcd_frame_scanner u0 (
        .clock(clk), .reset(rst), .start(s0),
        .xAddLCD(xa0), .yAddLCD(ya0), .pixelData(pd0),
        .pix_data(d0), .pix_valid(v0), .pix_ready(r0), .pix_first(f0),
        .busy(b0), .done(dn0)
    );

    // One-cycle pixel source for instance 0.
    always @(posedge clk) pd0 <= pix_of(int'(xa0), int'(ya0));

    // ---------------- instance 1: 3x2 frame, latency 3 ----------------
    logic        s1, r1, v1, f1, b1, dn1;
    logic [7:0]  xa1;
    logic [8:0]  ya1;
    logic [15:0] pd1, d1;
    logic [15:0] dl1 [3];

    lcd_frame_scanner #(.H_PIXELS(3), .V_PIXELS(2), .SRC_LATENCY(3)) u1 (
        .clock(clk), .reset(rst), .start(s1),
        .xAddLCD(xa1), .yAddLCD(ya1), .pixelData(pd1),
        .pix_data(d1), .pix_valid(v1), .pix_ready(r1), .pix_first(f1),
        .busy(b1), .done(dn1)
    );

    // Three-cycle pixel source for instance 1.
    always @(posedge clk) begin
        dl1[0] <= pix_of(int'(xa1), int'(ya1));
        dl1[1] <= dl1[0];
        dl1[2] <= dl1[1];
    end
    assign pd1 = dl1[2];

    // ---------------- instance 2: 2x2 frame, latency 1 ----------------
    logic        s2, r2, v2, f2, b2, dn2;
    logic [7:0]  xa2;
    logic [8:0]  ya2;
    logic [15:0] pd2, d2;

    lcd_frame_scanner #(.H_PIXELS(2), .V_PIXELS(2), .SRC_LATENCY(1)) u2 (
        .clock(clk), .reset(rst), .start(s2),
        .xAddLCD(xa2), .yAddLCD(ya2), .pixelData(pd2),
        .pix_data(d2), .pix_valid(v2), .pix_ready(r2), .pix_first(f2),
        .busy(b2), .done(dn2)
    );

    // One-cycle pixel source for instance 2.
    always @(posedge clk) pd2 <= pix_of(int'(xa2), int'(ya2));

    // ---------------- transfer monitors ----------------
    int   k0, ex0, ey0, stall0, last0;
    logic seen0;
    int   dcnt0 = 0;

    // Instance 0: each transfer must be the next raster pixel, 3 cycles apart plus stalls.
    always @(negedge clk) begin
        #2;
        if (rst) begin
            k0 = 0; ex0 = 0; ey0 = 0; stall0 = 0; seen0 = 1'b0;
        end else if (v0) begin
            if (r0) begin
                chk("m0_data", d0, pix_of(ex0, ey0));
                chk("m0_first", f0, (ex0 == 0 && ey0 == 0));
                chk("m0_x", xa0, ex0);
                chk("m0_y", ya0, ey0);
                if (seen0) chk("m0_spacing", cyc - last0, 3 + stall0);
                seen0 = 1'b1; last0 = cyc; stall0 = 0; k0++;
                if (ex0 == 239) begin ex0 = 0; ey0 = (ey0 == 319) ? 0 : ey0 + 1; end
                else ex0++;
            end else begin
                stall0++;
            end
        end
    end

    // Count done pulses of instance 0.
    always @(negedge clk) if (dn0) dcnt0++;

    int   k1, ex1, ey1, stall1, last1;
    logic seen1;

    // Instance 1: raster order, data matches presented address, 5 cycles per pixel.
    always @(negedge clk) begin
        #2;
        if (rst) begin
            k1 = 0; ex1 = 0; ey1 = 0; stall1 = 0; seen1 = 1'b0;
        end else begin
            if (dn1) seen1 = 1'b0;
            if (v1) begin
                if (r1) begin
                    chk("m1_data", d1, pix_of(ex1, ey1));
                    chk("m1_first", f1, (ex1 == 0 && ey1 == 0));
                    chk("m1_x", xa1, ex1);
                    chk("m1_y", ya1, ey1);
                    if (seen1) chk("m1_spacing", cyc - last1, 5 + stall1);
                    seen1 = 1'b1; last1 = cyc; stall1 = 0; k1++;
                    if (ex1 == 2) begin ex1 = 0; ey1 = (ey1 == 1) ? 0 : ey1 + 1; end
                    else ex1++;
                end else begin
                    stall1++;
                end
            end
        end
    end

    // ---------------- vector table for instance 2 ----------------
    typedef struct {
        logic        start;
        logic        ready;
        logic        valid;
        logic        first;
        logic [15:0] data;
        logic [7:0]  x;
        logic [8:0]  y;
        logic        busy;
        logic        done;
        logic        chk_addr;
    } vec_t;

    vec_t tbl [19];

    function automatic vec_t mk(input logic s, input logic r, input logic v, input logic f,
                                input logic [15:0] d, input logic [7:0] x, input logic [8:0] y,
                                input logic b, input logic dn, input logic ca);
        vec_t t;
        t.start = s; t.ready = r; t.valid = v; t.first = f; t.data = d;
        t.x = x; t.y = y; t.busy = b; t.done = dn; t.chk_addr = ca;
        return t;
    endfunction

    // Directed test sequence.
    initial begin
        int   t;
        logic found;
        int   dn_at;
        int   dc;

        //            st  rd  vld fst data      x  y  bsy dn ca
        tbl[0]  = mk(1, 0, 0, 0, 16'h0000, 0, 0, 1, 0, 1);
        tbl[1]  = mk(0, 1, 0, 0, 16'h0000, 0, 0, 1, 0, 1);
        tbl[2]  = mk(1, 0, 1, 1, 16'hA53C, 0, 0, 1, 0, 1);
        tbl[3]  = mk(0, 0, 1, 1, 16'hA53C, 0, 0, 1, 0, 1);
        tbl[4]  = mk(0, 1, 0, 0, 16'h0000, 1, 0, 1, 0, 1);
        tbl[5]  = mk(0, 1, 0, 0, 16'h0000, 1, 0, 1, 0, 1);
        tbl[6]  = mk(0, 1, 1, 0, 16'hA53D, 1, 0, 1, 0, 1);
        tbl[7]  = mk(0, 1, 0, 0, 16'h0000, 0, 1, 1, 0, 1);
        tbl[8]  = mk(0, 1, 0, 0, 16'h0000, 0, 1, 1, 0, 1);
        tbl[9]  = mk(0, 1, 1, 0, 16'hA43C, 0, 1, 1, 0, 1);
        tbl[10] = mk(0, 1, 0, 0, 16'h0000, 1, 1, 1, 0, 1);
        tbl[11] = mk(0, 1, 0, 0, 16'h0000, 1, 1, 1, 0, 1);
        tbl[12] = mk(0, 1, 1, 0, 16'hA43D, 1, 1, 1, 0, 1);
        tbl[13] = mk(1, 1, 0, 0, 16'h0000, 0, 0, 0, 1, 0);
        tbl[14] = mk(1, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0);
        tbl[15] = mk(0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0);
        tbl[16] = mk(1, 0, 0, 0, 16'h0000, 0, 0, 1, 0, 1);
        tbl[17] = mk(0, 0, 0, 0, 16'h0000, 0, 0, 1, 0, 1);
        tbl[18] = mk(0, 1, 1, 1, 16'hA53C, 0, 0, 1, 0, 1);

        rst = 1'b1;
        s0 = 1'b0; s1 = 1'b0; s2 = 1'b0;
        r0 = 1'b1; r1 = 1'b1; r2 = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state.
        chk("rst_x0", xa0, 0);
        chk("rst_y0", ya0, 0);
        chk("rst_data0", d0, 0);
        chk("rst_valid0", v0, 0);
        chk("rst_first0", f0, 0);
        chk("rst_busy0", b0, 0);
        chk("rst_done0", dn0, 0);
        chk("rst_busy1", b1, 0);
        chk("rst_valid2", v2, 0);
        #1 rst = 1'b0;

        // 2x2 frame, cycle by cycle.
        for (int i = 0; i < 19; i++) begin
            s2 = tbl[i].start;
            r2 = tbl[i].ready;
            @(negedge clk);
            chk($sformatf("t%0d_valid", i), v2, tbl[i].valid);
            chk($sformatf("t%0d_busy", i), b2, tbl[i].busy);
            chk($sformatf("t%0d_done", i), dn2, tbl[i].done);
            if (tbl[i].valid) begin
                chk($sformatf("t%0d_data", i), d2, tbl[i].data);
                chk($sformatf("t%0d_first", i), f2, tbl[i].first);
            end
            if (tbl[i].chk_addr) begin
                chk($sformatf("t%0d_x", i), xa2, tbl[i].x);
                chk($sformatf("t%0d_y", i), ya2, tbl[i].y);
            end
            #1;
        end
        s2 = 1'b0;

        // Instance 1: latency 3, extra starts mid-frame and on the DONE cycle.
        s1 = 1'b1;
        dn_at = -1;
        dc = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (dn1) begin
                dc++;
                if (dn_at < 0) dn_at = n;
            end
            if (n == 30) chk("l3_busy_last", b1, 1);
            if (n == 31) chk("l3_busy_at_done", b1, 0);
            if (n == 35) chk("l3_no_restart", b1, 0);
            #1;
            s1 = (n == 7 || n == 20 || n == 31);
        end
        chk("l3_done_count", dc, 1);
        chk("l3_done_cycle", dn_at, 31);
        chk("l3_xfers", k1, 6);

        // Fresh frame from IDLE.
        s1 = 1'b1;
        @(negedge clk);
        #1 s1 = 1'b0;
        found = 1'b0;
        for (t = 0; t < 60 && !found; t++) begin
            @(negedge clk);
            if (dn1) found = 1'b1;
        end
        chk("l3_frame2_done", found, 1);
        chk("l3_frame2_xfers", k1, 12);
        #1;

        // Instance 0: backpressure at (239,0).
        s0 = 1'b1;
        @(negedge clk);
        #1 s0 = 1'b0;
        found = 1'b0;
        for (t = 0; t < 1000 && !found; t++) begin
            @(negedge clk);
            if (v0 && xa0 == 8'd239 && ya0 == 9'd0) found = 1'b1;
        end
        chk("bp_reach", found, 1);
        #1 r0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", v0, 1);
            chk("bp_hold_data", d0, pix_of(239, 0));
            chk("bp_hold_x", xa0, 239);
            chk("bp_hold_y", ya0, 0);
            #1;
        end
        r0 = 1'b1;
        @(negedge clk);
        chk("bp_after_valid", v0, 0);
        chk("bp_after_x", xa0, 0);
        chk("bp_after_y", ya0, 1);
        chk("bp_count", k0, 240);
        #1;

        // Instance 0: asynchronous reset in the SEND of (100,57).
        found = 1'b0;
        for (t = 0; t < 45000 && !found; t++) begin
            @(negedge clk);
            if (v0 && xa0 == 8'd100 && ya0 == 9'd57) found = 1'b1;
        end
        chk("ar_reach", found, 1);
        #1 r0 = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("ar_x", xa0, 0);
        chk("ar_y", ya0, 0);
        chk("ar_data", d0, 0);
        chk("ar_valid", v0, 0);
        chk("ar_first", f0, 0);
        chk("ar_busy", b0, 0);
        chk("ar_done", dn0, 0);
        chk("ar_count", k0, 57 * 240 + 100);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        r0 = 1'b1;
        chk("ar_no_done", dcnt0, 0);

        s0 = 1'b1;
        @(negedge clk);
        #1 s0 = 1'b0;
        for (t = 0; t < 50 && k0 < 2; t++) @(negedge clk);
        chk("ar_restart", (k0 >= 2), 1);
        chk("ar_no_done_end", dcnt0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
